// File: rtl/mult_shift_add.sv
// Sequential shift-add multiplier: WIDTH x WIDTH product built in {A,B} over
// 2*WIDTH cycles, signed or unsigned, with chaining through register B.
module mult_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearXA_LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic             Signed_Mode,
  output logic             X,
  output logic             M,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, a_next;
  logic [WIDTH-1:0] b, b_next;
  logic [WIDTH-1:0] s, s_next;
  logic             x, x_next;
  logic             mode, mode_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH:0]   ext_a, ext_s, sum;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      x     <= 1'b0;
      mode  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      a     <= a_next;
      b     <= b_next;
      s     <= s_next;
      x     <= x_next;
      mode  <= mode_next;
      cnt   <= cnt_next;
    end
  end

  // The top multiplier bit carries negative weight in signed mode, so the
  // last partial product is subtracted instead of added.
  always_comb begin
    state_next = state;
    a_next     = a;
    b_next     = b;
    s_next     = s;
    x_next     = x;
    mode_next  = mode;
    cnt_next   = cnt;
    ext_a      = {mode & a[WIDTH-1], a};
    ext_s      = {mode & s[WIDTH-1], s};
    sum        = (mode && (cnt == LAST)) ? (ext_a - ext_s) : (ext_a + ext_s);

    case (state)
      IDLE: begin
        if (ClearXA_LoadB) begin
          b_next = Din;
          a_next = '0;
          x_next = 1'b0;
        end else if (Execute) begin
          a_next     = '0;
          x_next     = 1'b0;
          s_next     = Din;
          mode_next  = Signed_Mode;
          cnt_next   = '0;
          state_next = ADD;
        end
      end
      ADD: begin
        if (b[0]) {x_next, a_next} = sum;
        state_next = SHIFT;
      end
      SHIFT: begin
        a_next = {x, a[WIDTH-1:1]};
        b_next = {a[0], b[WIDTH-1:1]};
        // An unsigned carry is consumed by the shift; a sign bit must persist.
        if (!mode) x_next = 1'b0;
        if (cnt == LAST) begin
          state_next = HOLD;
        end else begin
          cnt_next   = cnt + CW'(1);
          state_next = ADD;
        end
      end
      HOLD: begin
        if (!Execute) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign X    = x;
  assign M    = b[0];
  assign Aval = a;
  assign Bval = b;
  assign Busy = (state == ADD) || (state == SHIFT);
  assign Done = (state == HOLD);

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed-vector bench for mult_shift_add at WIDTH=8 and WIDTH=16, plus
// hand-written reset, hold, chaining and busy-input sequences.
module tb_mult_shift_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic load8, exec8, sm8, x8, m8, busy8, done8;
  logic [7:0] din8, a8, b8;
  logic load16, exec16, sm16, x16, m16, busy16, done16;
  logic [15:0] din16, a16, b16;

  int applied = 0;
  int miscompares = 0;
  logic wide = 1'b0;

  mult_shift_add #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .ClearXA_LoadB(load8), .Execute(exec8), .Din(din8),
    .Signed_Mode(sm8), .X(x8), .M(m8), .Aval(a8), .Bval(b8), .Busy(busy8), .Done(done8)
  );

  mult_shift_add #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(rst), .ClearXA_LoadB(load16), .Execute(exec16), .Din(din16),
    .Signed_Mode(sm16), .X(x16), .M(m16), .Aval(a16), .Bval(b16), .Busy(busy16), .Done(done16)
  );

  typedef struct {
    logic        wide;
    logic [15:0] b;
    logic [15:0] din;
    logic        sm;
    logic [31:0] prod;
    logic        x;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] product();
    return wide ? {a16, b16} : {16'h0, a8, b8};
  endfunction

  function automatic logic cur_x();
    return wide ? x16 : x8;
  endfunction

  function automatic logic cur_busy();
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic cur_done();
    return wide ? done16 : done8;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic load, input logic exec, input logic sm, input logic [15:0] din);
    if (wide) begin
      load16 = load; exec16 = exec; sm16 = sm; din16 = din;
    end else begin
      load8 = load; exec8 = exec; sm8 = sm; din8 = din[7:0];
    end
  endtask

  task automatic load_b(input logic [15:0] b);
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 1'b0, b);
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0);
    check_output("load_b", product(), {16'h0, b});
  endtask

  // Starts a multiply and waits (bounded) for Done; optionally wiggles the
  // ignored inputs while Busy.
  task automatic apply_stimulus(input logic [15:0] din, input logic sm, input logic wiggle, output int lat);
    logic overlap;
    overlap = 1'b0;
    @(negedge clk);
    set_inputs(1'b0, 1'b1, sm, din);
    @(posedge clk);
    #1;
    lat = 0;
    while (!cur_done() && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (cur_busy() && cur_done()) overlap = 1'b1;
      if (wiggle && cur_busy()) set_inputs(lat[0], 1'b1, ~sm, 16'hAAAA);
    end
    set_inputs(1'b0, 1'b1, sm, din);
    check_output("busy_done_exclusive", {31'h0, overlap}, 32'h0);
  endtask

  task automatic release_exec();
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 16'h03,   16'h07,   1'b1, 32'h0000_0015, 1'b0};
    vecs[1]  = '{1'b0, 16'hFD,   16'h07,   1'b1, 32'h0000_FFEB, 1'b1};
    vecs[2]  = '{1'b0, 16'hFD,   16'hF9,   1'b1, 32'h0000_0015, 1'b0};
    vecs[3]  = '{1'b0, 16'h80,   16'h80,   1'b1, 32'h0000_4000, 1'b0};
    vecs[4]  = '{1'b0, 16'h7F,   16'h80,   1'b1, 32'h0000_C080, 1'b1};
    vecs[5]  = '{1'b0, 16'hFF,   16'hFF,   1'b0, 32'h0000_FE01, 1'b0};
    vecs[6]  = '{1'b0, 16'h80,   16'h02,   1'b0, 32'h0000_0100, 1'b0};
    vecs[7]  = '{1'b0, 16'hFF,   16'h01,   1'b1, 32'h0000_FFFF, 1'b1};
    vecs[8]  = '{1'b0, 16'h7F,   16'h7F,   1'b0, 32'h0000_3F01, 1'b0};
    vecs[9]  = '{1'b0, 16'hFF,   16'hFF,   1'b1, 32'h0000_0001, 1'b0};
    vecs[10] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001, 1'b0};
    vecs[11] = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0};

    rst = 1'b1;
    load8 = 0; exec8 = 0; sm8 = 0; din8 = '0;
    load16 = 0; exec16 = 0; sm16 = 0; din16 = '0;
    #12;
    for (int w = 0; w < 2; w++) begin
      wide = (w == 1);
      check_output("reset_product", product(), 32'h0);
      check_output("reset_x", {31'h0, cur_x()}, 32'h0);
      check_output("reset_busy_done", {30'h0, cur_busy(), cur_done()}, 32'h0);
    end
    check_output("reset_m8", {31'h0, m8}, 32'h0);
    check_output("reset_m16", {31'h0, m16}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      wide = vecs[i].wide;
      load_b(vecs[i].b);
      apply_stimulus(vecs[i].din, vecs[i].sm, 1'b0, lat);
      check_output($sformatf("latency_%0d", i), lat, wide ? 32 : 16);
      check_output($sformatf("product_%0d", i), product(), vecs[i].prod);
      check_output($sformatf("x_%0d", i), {31'h0, cur_x()}, {31'h0, vecs[i].x});
      release_exec();
    end

    // Held Execute yields one multiply; result then chains into the next.
    wide = 1'b0;
    load_b(16'h03);
    apply_stimulus(16'h07, 1'b1, 1'b0, lat);
    repeat (40) @(negedge clk);
    check_output("hold_done", {31'h0, done8}, 32'h1);
    check_output("hold_busy", {31'h0, busy8}, 32'h0);
    check_output("hold_product", product(), 32'h0015);
    release_exec();
    check_output("idle_after_release", {31'h0, done8}, 32'h0);
    apply_stimulus(16'h02, 1'b1, 1'b1, lat);
    check_output("chain_latency", lat, 16);
    check_output("chain_product", product(), 32'h002A);
    check_output("chain_x", {31'h0, x8}, 32'h0);
    release_exec();

    // Reset in the middle of an ADD cycle aborts immediately.
    load_b(16'h03);
    @(negedge clk);
    set_inputs(1'b0, 1'b1, 1'b1, 16'h07);
    repeat (3) @(posedge clk);
    #1;
    check_output("pre_reset_busy", {31'h0, busy8}, 32'h1);
    rst = 1'b1;
    #1;
    check_output("midreset_product", product(), 32'h0);
    check_output("midreset_x_m", {30'h0, x8, m8}, 32'h0);
    check_output("midreset_busy_done", {30'h0, busy8, done8}, 32'h0);
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(16'h5A, 1'b1, 1'b0, lat);
    check_output("post_reset_latency", lat, 16);
    check_output("post_reset_product", product(), 32'h0);
    release_exec();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
